// File: rtl/memory_unit.sv
// memory_unit
// Sequential Wishbone-classic bus master shared by the instruction fetch and
// data access paths of the pipelined core. Each step performs an optional data
// access (load or store) followed by one instruction fetch, then spends one
// cycle in DONE with mem_busy low so the pipeline can advance.
//
// Ports:
//   clock, reset      : clock and asynchronous active-high reset
//   inst_addr         : fetch address (PC), stable while mem_busy=1
//   inst              : registered fetched instruction word
//   data_rd_en        : load request for the coming step
//   data_wr_en        : store request for the coming step (wins over load)
//   data_byte_en      : byte lanes for the data access
//   data_addr         : data access address
//   data_wr_data      : store data
//   data_rd_data      : registered raw load data
//   mem_busy          : step in progress, pipeline must hold
//   bus_cyc, bus_stb  : Wishbone cycle / strobe
//   bus_we            : Wishbone write enable
//   bus_sel           : Wishbone byte select
//   bus_addr          : Wishbone address
//   bus_dat_w         : Wishbone write data
//   bus_dat_r         : Wishbone read data
//   bus_ack           : Wishbone acknowledge
module memory_unit #(
  parameter int DATA_SIZE = 32,
  parameter int BYTE_NUM  = DATA_SIZE / 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] inst_addr,
  output logic [31:0]          inst,
  input  logic                 data_rd_en,
  input  logic                 data_wr_en,
  input  logic [BYTE_NUM-1:0]  data_byte_en,
  input  logic [DATA_SIZE-1:0] data_addr,
  input  logic [DATA_SIZE-1:0] data_wr_data,
  output logic [DATA_SIZE-1:0] data_rd_data,
  output logic                 mem_busy,
  output logic                 bus_cyc,
  output logic                 bus_stb,
  output logic                 bus_we,
  output logic [BYTE_NUM-1:0]  bus_sel,
  output logic [DATA_SIZE-1:0] bus_addr,
  output logic [DATA_SIZE-1:0] bus_dat_w,
  input  logic [DATA_SIZE-1:0] bus_dat_r,
  input  logic                 bus_ack
);

  typedef enum logic [1:0] {
    S_DATA  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic   [31:0]          r_inst;
  logic   [DATA_SIZE-1:0] r_data_rd_data;
  logic                   w_load_ack;
  logic                   w_fetch_ack;

  // A simultaneous load+store request is a store, so only a pure load captures.
  assign w_load_ack  = (r_state == S_DATA) && bus_ack && data_rd_en && !data_wr_en;
  assign w_fetch_ack = (r_state == S_FETCH) && bus_ack;

  // State register; reset restarts the step with a fetch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: DATA -> FETCH -> DONE, with DONE sampling the new request.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_DATA: begin
        if (bus_ack) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_DATA;
        end
      end
      S_FETCH: begin
        if (bus_ack) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DONE: begin
        if (data_rd_en || data_wr_en) begin
          w_next_state = S_DATA;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

  // Instruction capture register, loaded only on the fetch acknowledge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_inst <= 32'd0;
    end else if (w_fetch_ack) begin
      r_inst <= bus_dat_r[31:0];
    end else begin
      r_inst <= r_inst;
    end
  end

  // Load data capture register, loaded only on a load acknowledge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data_rd_data <= '0;
    end else if (w_load_ack) begin
      r_data_rd_data <= bus_dat_r;
    end else begin
      r_data_rd_data <= r_data_rd_data;
    end
  end

  // Bus drive: steered by state; cyc/stb are held off while reset is asserted
  // so a reset mid-access drops the cycle without waiting for a clock edge.
  always_comb begin
    bus_cyc   = 1'b0;
    bus_stb   = 1'b0;
    bus_we    = 1'b0;
    bus_sel   = '0;
    bus_addr  = '0;
    bus_dat_w = '0;
    case (r_state)
      S_DATA: begin
        bus_cyc   = !reset;
        bus_stb   = !reset;
        bus_we    = data_wr_en;
        bus_sel   = data_byte_en;
        bus_addr  = data_addr;
        bus_dat_w = data_wr_data;
      end
      S_FETCH: begin
        bus_cyc   = !reset;
        bus_stb   = !reset;
        bus_we    = 1'b0;
        bus_sel   = {BYTE_NUM{1'b1}};
        bus_addr  = inst_addr;
        bus_dat_w = '0;
      end
      S_DONE: begin
        bus_cyc   = 1'b0;
        bus_stb   = 1'b0;
      end
      default: begin
        bus_cyc   = 1'b0;
        bus_stb   = 1'b0;
      end
    endcase
  end

  assign mem_busy     = (r_state != S_DONE);
  assign inst         = r_inst;
  assign data_rd_data = r_data_rd_data;

endmodule

// File: tb/tb_memory_unit.sv
// Self-checking bench for memory_unit. The bench acts as the Wishbone slave,
// driving and sampling on the falling clock edge. Expected captured values are
// pushed to scoreboard queues when the acknowledge is driven and popped when
// the DUT reaches the cycle where the value must be visible.
module tb_memory_unit;

  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clock;
  logic          reset;
  logic [DW-1:0] inst_addr;
  logic [31:0]   inst;
  logic          data_rd_en;
  logic          data_wr_en;
  logic [BW-1:0] data_byte_en;
  logic [DW-1:0] data_addr;
  logic [DW-1:0] data_wr_data;
  logic [DW-1:0] data_rd_data;
  logic          mem_busy;
  logic          bus_cyc;
  logic          bus_stb;
  logic          bus_we;
  logic [BW-1:0] bus_sel;
  logic [DW-1:0] bus_addr;
  logic [DW-1:0] bus_dat_w;
  logic [DW-1:0] bus_dat_r;
  logic          bus_ack;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]   q_inst[$];
  logic [DW-1:0] q_rd[$];
  logic [31:0]   exp_inst = 32'd0;
  logic [DW-1:0] exp_rd   = 32'd0;

  memory_unit #(.DATA_SIZE(DW)) dut (
    .clock(clock), .reset(reset), .inst_addr(inst_addr), .inst(inst),
    .data_rd_en(data_rd_en), .data_wr_en(data_wr_en), .data_byte_en(data_byte_en),
    .data_addr(data_addr), .data_wr_data(data_wr_data), .data_rd_data(data_rd_data),
    .mem_busy(mem_busy), .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we),
    .bus_sel(bus_sel), .bus_addr(bus_addr), .bus_dat_w(bus_dat_w),
    .bus_dat_r(bus_dat_r), .bus_ack(bus_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave stimulus: ack the current cycle with data d, then step to the next
  // falling edge and withdraw the ack.
  task automatic ack_now(input logic [DW-1:0] d);
    bus_ack   = 1'b1;
    bus_dat_r = d;
    @(negedge clock);
    bus_ack   = 1'b0;
    bus_dat_r = 32'd0;
  endtask

  // Complete the FETCH state with a zero-wait ack and record the expectation.
  task automatic fetch_ack(input logic [31:0] w);
    q_inst.push_back(w);
    ack_now(w);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    n_tests++; if (bus_cyc !== 1'b0) begin n_fail++; $display("FAIL rst_cyc: got %b expected 0", bus_cyc); end
    n_tests++; if (bus_stb !== 1'b0) begin n_fail++; $display("FAIL rst_stb: got %b expected 0", bus_stb); end
    n_tests++; if (inst !== 32'd0) begin n_fail++; $display("FAIL rst_inst: got %h expected 0", inst); end
    n_tests++; if (data_rd_data !== 32'd0) begin n_fail++; $display("FAIL rst_rd: got %h expected 0", data_rd_data); end
    n_tests++; if (mem_busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b expected 1", mem_busy); end
    reset = 1'b0;
    #1;
    n_tests++; if (bus_cyc !== 1'b1 || bus_stb !== 1'b1) begin n_fail++; $display("FAIL fetch0_cyc: got %b%b expected 11", bus_cyc, bus_stb); end
    n_tests++; if (bus_addr !== 32'd0) begin n_fail++; $display("FAIL fetch0_addr: got %h expected 0", bus_addr); end
    n_tests++; if (bus_sel !== 4'hF) begin n_fail++; $display("FAIL fetch0_sel: got %h expected f", bus_sel); end
    n_tests++; if (bus_we !== 1'b0) begin n_fail++; $display("FAIL fetch0_we: got %b expected 0", bus_we); end
    fetch_ack(32'h0000_0013);
    exp_inst = q_inst.pop_front();
    n_tests++; if (mem_busy !== 1'b0) begin n_fail++; $display("FAIL fetch0_done_busy: got %b expected 0", mem_busy); end
    n_tests++; if (bus_cyc !== 1'b0) begin n_fail++; $display("FAIL fetch0_done_cyc: got %b expected 0", bus_cyc); end
    n_tests++; if (inst !== exp_inst) begin n_fail++; $display("FAIL fetch0_inst: got %h expected %h", inst, exp_inst); end
  endtask

  task automatic test_load();
    data_rd_en = 1'b1; data_addr = 32'h100; data_byte_en = 4'hF; inst_addr = 32'h4;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (mem_busy !== 1'b1 || bus_cyc !== 1'b1) begin n_fail++; $display("FAIL load_busy[%0d]: got %b%b expected 11", i, mem_busy, bus_cyc); end
      n_tests++; if (bus_addr !== 32'h100 || bus_we !== 1'b0 || bus_sel !== 4'hF) begin n_fail++; $display("FAIL load_bus[%0d]: got %h/%b/%h expected 100/0/f", i, bus_addr, bus_we, bus_sel); end
      n_tests++; if (data_rd_data !== exp_rd) begin n_fail++; $display("FAIL load_hold[%0d]: got %h expected %h", i, data_rd_data, exp_rd); end
      if (i < 2) @(negedge clock);
    end
    q_rd.push_back(32'hDEAD_BEEF);
    ack_now(32'hDEAD_BEEF);
    exp_rd = q_rd.pop_front();
    n_tests++; if (data_rd_data !== exp_rd) begin n_fail++; $display("FAIL load_data: got %h expected %h", data_rd_data, exp_rd); end
    n_tests++; if (bus_cyc !== 1'b1 || bus_addr !== 32'h4 || bus_we !== 1'b0) begin n_fail++; $display("FAIL load_b2b_fetch: got %b/%h/%b expected 1/4/0", bus_cyc, bus_addr, bus_we); end
    fetch_ack(32'h0010_0093);
    exp_inst = q_inst.pop_front();
    n_tests++; if (mem_busy !== 1'b0) begin n_fail++; $display("FAIL load_done_busy: got %b expected 0", mem_busy); end
    n_tests++; if (inst !== exp_inst) begin n_fail++; $display("FAIL load_inst: got %h expected %h", inst, exp_inst); end
    data_rd_en = 1'b0;
  endtask

  task automatic test_store(input logic rd_too, input logic [DW-1:0] addr,
                            input logic [BW-1:0] be, input logic [DW-1:0] wd);
    data_wr_en = 1'b1; data_rd_en = rd_too; data_addr = addr; data_byte_en = be;
    data_wr_data = wd; inst_addr = 32'h8;
    @(negedge clock);
    n_tests++; if (bus_we !== 1'b1 || bus_sel !== be || bus_addr !== addr) begin n_fail++; $display("FAIL store_bus: got %b/%h/%h expected 1/%h/%h", bus_we, bus_sel, bus_addr, be, addr); end
    n_tests++; if (bus_dat_w !== wd) begin n_fail++; $display("FAIL store_wdata: got %h expected %h", bus_dat_w, wd); end
    ack_now(32'h1234_5678);
    n_tests++; if (data_rd_data !== exp_rd) begin n_fail++; $display("FAIL store_rd_kept: got %h expected %h", data_rd_data, exp_rd); end
    n_tests++; if (bus_we !== 1'b0 || bus_dat_w !== 32'd0 || bus_addr !== 32'h8) begin n_fail++; $display("FAIL store_fetch_bus: got %b/%h/%h expected 0/0/8", bus_we, bus_dat_w, bus_addr); end
    fetch_ack(32'h00A0_0113 ^ wd);
    exp_inst = q_inst.pop_front();
    n_tests++; if (inst !== exp_inst || mem_busy !== 1'b0) begin n_fail++; $display("FAIL store_done: got %h/%b expected %h/0", inst, mem_busy, exp_inst); end
    data_wr_en = 1'b0; data_rd_en = 1'b0;
  endtask

  task automatic test_fetch_wait();
    int busy_cycles;
    busy_cycles = 0;
    inst_addr = 32'h40;
    @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      if (mem_busy === 1'b1) busy_cycles++;
      n_tests++; if (bus_addr !== 32'h40 || inst !== exp_inst) begin n_fail++; $display("FAIL fwait[%0d]: got %h/%h expected 40/%h", i, bus_addr, inst, exp_inst); end
      if (i < 5) @(negedge clock);
    end
    fetch_ack(32'h0000_0073);
    exp_inst = q_inst.pop_front();
    n_tests++; if (busy_cycles !== 6 || mem_busy !== 1'b0) begin n_fail++; $display("FAIL fwait_busy: got %0d/%b expected 6/0", busy_cycles, mem_busy); end
    n_tests++; if (inst !== exp_inst) begin n_fail++; $display("FAIL fwait_inst: got %h expected %h", inst, exp_inst); end
    // Stray ack in DONE must not capture anything.
    ack_now(32'hBAD0_BAD0);
    n_tests++; if (inst !== exp_inst || data_rd_data !== exp_rd) begin n_fail++; $display("FAIL stray_ack: got %h/%h expected %h/%h", inst, data_rd_data, exp_inst, exp_rd); end
    n_tests++; if (mem_busy !== 1'b1 || bus_addr !== 32'h40) begin n_fail++; $display("FAIL stray_next: got %b/%h expected 1/40", mem_busy, bus_addr); end
    fetch_ack(32'h0000_1037);
    exp_inst = q_inst.pop_front();
    n_tests++; if (inst !== exp_inst) begin n_fail++; $display("FAIL stray_fetch: got %h expected %h", inst, exp_inst); end
  endtask

  task automatic test_reset_mid();
    data_rd_en = 1'b1; data_addr = 32'h500; data_byte_en = 4'hF;
    @(negedge clock);
    n_tests++; if (bus_cyc !== 1'b1 || bus_addr !== 32'h500) begin n_fail++; $display("FAIL rmid_pre: got %b/%h expected 1/500", bus_cyc, bus_addr); end
    #2 reset = 1'b1;
    #1;
    exp_inst = 32'd0; exp_rd = 32'd0;
    n_tests++; if (bus_cyc !== 1'b0 || bus_stb !== 1'b0) begin n_fail++; $display("FAIL rmid_cyc: got %b%b expected 00", bus_cyc, bus_stb); end
    n_tests++; if (inst !== exp_inst || data_rd_data !== exp_rd) begin n_fail++; $display("FAIL rmid_regs: got %h/%h expected 0/0", inst, data_rd_data); end
    data_rd_en = 1'b0; inst_addr = 32'h80;
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_tests++; if (bus_cyc !== 1'b1 || bus_addr !== 32'h80 || bus_we !== 1'b0) begin n_fail++; $display("FAIL rmid_fetch: got %b/%h/%b expected 1/80/0", bus_cyc, bus_addr, bus_we); end
    n_tests++; if (inst !== 32'd0) begin n_fail++; $display("FAIL rmid_inst: got %h expected 0", inst); end
    fetch_ack(32'h0080_0067);
    exp_inst = q_inst.pop_front();
    n_tests++; if (inst !== exp_inst || mem_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_done: got %h/%b expected %h/0", inst, mem_busy, exp_inst); end
  endtask

  initial begin
    reset = 1'b1; inst_addr = 32'd0; data_rd_en = 1'b0; data_wr_en = 1'b0;
    data_byte_en = 4'h0; data_addr = 32'd0; data_wr_data = 32'd0;
    bus_dat_r = 32'd0; bus_ack = 1'b0;
    test_reset();
    test_load();
    test_store(1'b0, 32'h204, 4'h3, 32'h0000_CAFE);
    test_fetch_wait();
    test_store(1'b1, 32'h300, 4'hF, 32'h0000_55AA);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_unit.md
# memory_unit

Sequential bus master between the pipelined core's dataflow and a single shared Wishbone-classic memory bus. Each pipeline step issues at most one data access (load/store from the MEM stage), then one instruction fetch (IF stage, address = PC). The unit drives `mem_busy` high until both accesses complete, freezing the pipeline. The fetched instruction and loaded data are registered outputs, held stable while the pipeline advances.

## Interface
Parameters:
- DATA_SIZE, 32: data/address width (32 or 64).
- BYTE_NUM, DATA_SIZE/8: byte-enable width.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- inst_addr  in  DATA_SIZE  fetch address (PC), stable while mem_busy=1.
- inst  out  32  fetched instruction word.
- data_rd_en  in  1  load request for this step.
- data_wr_en  in  1  store request for this step.
- data_byte_en  in  BYTE_NUM  byte lanes for the data access.
- data_addr  in  DATA_SIZE  data address.
- data_wr_data  in  DATA_SIZE  store data.
- data_rd_data  out  DATA_SIZE  raw load data, no extension.
- mem_busy  out  1  step in progress; pipeline must hold.
- bus_cyc, bus_stb  out  1  bus cycle/strobe.
- bus_we  out  1  write strobe.
- bus_sel  out  BYTE_NUM  byte select.
- bus_addr  out  DATA_SIZE  bus address.
- bus_dat_w  out  DATA_SIZE  bus write data.
- bus_dat_r  in  DATA_SIZE  bus read data.
- bus_ack  in  1  slave acknowledge, one cycle per transfer.

## Operation
- FSM states: DATA, FETCH, DONE. Reset state FETCH.
- DATA:
  - bus_cyc=bus_stb=1, bus_addr=data_addr, bus_sel=data_byte_en, bus_we=data_wr_en, bus_dat_w=data_wr_data.
  - On bus_ack: if load, capture bus_dat_r into data_rd_data; go to FETCH.
- FETCH:
  - bus_cyc=bus_stb=1, bus_we=0, bus_sel=all ones, bus_addr=inst_addr.
  - On bus_ack: capture bus_dat_r[31:0] into inst; go to DONE.
- DONE:
  - bus_cyc=bus_stb=0; mem_busy=0.
  - Next state is DATA if data_rd_en|data_wr_en, else FETCH. Inputs are sampled at this edge, i.e. the same edge at which the pipeline advances.
- mem_busy = (state != DONE), combinational from state.
- bus_* outputs are combinational from state and inputs. Inputs are stable because the pipeline is frozen while busy.
- data_rd_en and data_wr_en both set: treated as a store; data_rd_data unchanged.
- Stores never modify data_rd_data.
- inst and data_rd_data hold their values in all states except on their own capturing ack.
- bus_ack is ignored in DONE, and while reset is asserted.
- Outside DATA: bus_dat_w=0, bus_we=0.

## Timing
- Reset values: inst=0, data_rd_data=0, state=FETCH, mem_busy=1, bus_cyc=bus_stb=1 after reset release.
- While reset is asserted, bus_cyc/stb are forced 0.
- A combinational ack (same cycle as stb) gives a minimum step length of:
  - 2 cycles without a data access (FETCH, DONE);
  - 3 cycles with one (DATA, FETCH, DONE).
- Each slave wait state adds one cycle to the corresponding state.
- DATA→FETCH transitions back-to-back: cyc/stb stay high, and addr/sel/we switch on the ack edge.
- mem_busy is low for exactly one cycle per step.
- Reset mid-access:
  - state returns to FETCH asynchronously and bus_cyc drops immediately;
  - captured registers reset to 0;
  - the slave must share the same reset.
- Address wrap: none; addresses pass through unmodified.

## Test plan
- Reset, then release with inst_addr=0 and slave acking with 0x00000013 in the first FETCH cycle → bus_addr=0, bus_sel=0xF; inst=0x00000013 in DONE; mem_busy pattern 1,0.
- Load: in DONE, data_rd_en=1, data_addr=0x100, data_byte_en=0xF; slave acks 0xDEADBEEF after 2 wait states → DATA lasts 3 cycles with bus_we=0, then data_rd_data=0xDEADBEEF, then FETCH.
- Store: data_wr_en=1, data_addr=0x204, data_byte_en=0x3, data_wr_data=0xCAFE → DATA cycle has bus_we=1, bus_sel=0x3, bus_dat_w=0xCAFE; data_rd_data unchanged.
- Fetch with 5 wait states → mem_busy high 6 cycles; inst updates only on the ack edge; stray ack in DONE changes nothing.
- Both rd/wr enables high → behaves as a store.
- Assert reset during DATA wait states → bus_cyc=0 immediately; after release, FETCH from inst_addr with inst=0.
